// File: rtl/aes_pkg.sv
// Shared AES constants and types for the inverse SubBytes datapath.
// The state is a packed byte array whose element [NUM_BYTES-1] is byte 0 (bits 127:120).
package aes_pkg;

    localparam int STATE_WIDTH = 128;
    localparam int BYTE_WIDTH  = 8;
    localparam int NUM_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE,
        PROCESS,
        DONE
    } fsm_state_t;

    typedef logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] aes_state_t;

endpackage

// File: rtl/inv_sbox.sv
// Combinational FIPS-197 inverse S-box, one byte in, one byte out.
// The table is written row by row from entry 0x00, so entry i lives at element 255-i.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [BYTE_WIDTH-1:0] value,
    output logic [BYTE_WIDTH-1:0] inverse
);

    localparam logic [255:0][BYTE_WIDTH-1:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // ~value == 255 - value for an 8-bit index
    assign inverse = INV_SBOX_TABLE[~value];

endmodule

// File: rtl/inv_sub_byte_seq.sv
// Sequential AES InvSubBytes: transforms BYTES_PER_CYCLE bytes per cycle, byte 0 first,
// and publishes the full 128-bit result only when every byte has been replaced.
module inv_sub_byte_seq
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   startTransition,
    input  logic [STATE_WIDTH-1:0] invSubByteInput,
    output logic [STATE_WIDTH-1:0] invSubByteOutput,
    output logic                   busy,
    output logic                   done
);

    localparam logic [3:0] STEP      = 4'(BYTES_PER_CYCLE);
    localparam logic [3:0] LAST_CNT  = 4'(NUM_BYTES - BYTES_PER_CYCLE);
    localparam logic [3:0] TOP_INDEX = 4'(NUM_BYTES - 1);

    fsm_state_t           state;
    logic [3:0]           byte_cnt;
    aes_state_t           work;
    aes_state_t           next_work;
    logic [BYTE_WIDTH-1:0] sbox_out [BYTES_PER_CYCLE];

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        logic [3:0]            byte_idx;
        logic [BYTE_WIDTH-1:0] sbox_in;

        assign byte_idx = byte_cnt + 4'(g);
        assign sbox_in  = work[TOP_INDEX - byte_idx];

        inv_sbox u_inv_sbox (
            .value   (sbox_in),
            .inverse (sbox_out[g])
        );
    end

    always_comb begin
        next_work = work;
        for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
            next_work[TOP_INDEX - (byte_cnt + 4'(g))] = sbox_out[g];
        end
    end

    // The last PROCESS cycle is detected before the add, so the 4-bit counter never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            byte_cnt         <= '0;
            work             <= '0;
            invSubByteOutput <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (startTransition) begin
                        work     <= invSubByteInput;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= PROCESS;
                    end
                end
                PROCESS: begin
                    work <= next_work;
                    if (byte_cnt == LAST_CNT) begin
                        invSubByteOutput <= next_work;
                        byte_cnt         <= '0;
                        busy             <= 1'b0;
                        done             <= 1'b1;
                        state            <= DONE;
                    end else begin
                        byte_cnt <= byte_cnt + STEP;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sub_byte_seq.sv
// Directed bench for inv_sub_byte_seq at 4, 1 and 16 bytes per cycle.
// Cycle k is the interval after acceptance edge N+k-1; outputs are sampled on the falling edge.
module tb_inv_sub_byte_seq;

    localparam logic [127:0] VEC_IN   = 128'h63cab7040953d051cd60e0e7ba70e18c;
    localparam logic [127:0] VEC_OUT  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] ALL_63   = {16{8'h63}};
    localparam logic [127:0] ALL_00   = {16{8'h00}};
    localparam logic [127:0] ALL_7C   = {16{8'h7c}};
    localparam logic [127:0] ALL_52   = {16{8'h52}};
    localparam logic [127:0] ALL_01   = {16{8'h01}};

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start_transition = 1'b0;
    logic [127:0] data_in = '0;

    logic [127:0] out4, out1, out16;
    logic         busy4, busy1, busy16;
    logic         done4, done1, done16;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    inv_sub_byte_seq #(.BYTES_PER_CYCLE(4)) dut4 (
        .clock            (clock),
        .reset            (reset),
        .startTransition  (start_transition),
        .invSubByteInput  (data_in),
        .invSubByteOutput (out4),
        .busy             (busy4),
        .done             (done4)
    );

    inv_sub_byte_seq #(.BYTES_PER_CYCLE(1)) dut1 (
        .clock            (clock),
        .reset            (reset),
        .startTransition  (start_transition),
        .invSubByteInput  (data_in),
        .invSubByteOutput (out1),
        .busy             (busy1),
        .done             (done1)
    );

    inv_sub_byte_seq #(.BYTES_PER_CYCLE(16)) dut16 (
        .clock            (clock),
        .reset            (reset),
        .startTransition  (start_transition),
        .invSubByteInput  (data_in),
        .invSubByteOutput (out16),
        .busy             (busy16),
        .done             (done16)
    );

    task automatic do_reset();
        start_transition = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Raises start during cycle 0 so it is accepted at the next rising edge.
    task automatic begin_start(input logic [127:0] value);
        @(posedge clock);
        #1;
        data_in = value;
        start_transition = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (out4 !== 128'h0) $display("FAIL reset_out4: got %h expected %h", out4, 128'h0); else n_pass++;
        n_checks++; if (busy4 !== 1'b0) $display("FAIL reset_busy4: got %b expected 0", busy4); else n_pass++;
        n_checks++; if (done4 !== 1'b0) $display("FAIL reset_done4: got %b expected 0", done4); else n_pass++;
        n_checks++; if (out1 !== 128'h0) $display("FAIL reset_out1: got %h expected %h", out1, 128'h0); else n_pass++;
        n_checks++; if (out16 !== 128'h0) $display("FAIL reset_out16: got %h expected %h", out16, 128'h0); else n_pass++;
    endtask

    task automatic test_basic();
        logic         exp_busy, exp_done;
        logic [127:0] exp_out;
        do_reset();
        begin_start(VEC_IN);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clock);
            #1 start_transition = 1'b0;
            @(negedge clock);
            exp_busy = (k >= 1 && k <= 4);
            exp_done = (k == 5);
            exp_out  = (k >= 5) ? VEC_OUT : 128'h0;
            n_checks++; if (busy4 !== exp_busy) $display("FAIL basic_busy cycle %0d: got %b expected %b", k, busy4, exp_busy); else n_pass++;
            n_checks++; if (done4 !== exp_done) $display("FAIL basic_done cycle %0d: got %b expected %b", k, done4, exp_done); else n_pass++;
            n_checks++; if (out4 !== exp_out) $display("FAIL basic_out cycle %0d: got %h expected %h", k, out4, exp_out); else n_pass++;
        end
    endtask

    task automatic test_patterns();
        logic [127:0] pin  [3];
        logic [127:0] pout [3];
        int           cyc;
        pin[0] = ALL_63; pout[0] = ALL_00;
        pin[1] = ALL_00; pout[1] = ALL_52;
        pin[2] = ALL_7C; pout[2] = ALL_01;
        for (int p = 0; p < 3; p++) begin
            begin_start(pin[p]);
            cyc = -1;
            for (int k = 1; k <= 8; k++) begin
                @(posedge clock);
                #1 start_transition = 1'b0;
                @(negedge clock);
                if (done4 && cyc < 0) cyc = k;
            end
            n_checks++; if (cyc !== 5) $display("FAIL pattern%0d_latency: got %0d expected 5", p, cyc); else n_pass++;
            n_checks++; if (out4 !== pout[p]) $display("FAIL pattern%0d_out: got %h expected %h", p, out4, pout[p]); else n_pass++;
        end
    endtask

    task automatic test_ignore_start();
        logic         exp_busy, exp_done;
        logic [127:0] exp_out;
        do_reset();
        begin_start(VEC_IN);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            #1;
            start_transition = (k == 2 || k == 3);
            data_in = (k >= 2) ? ALL_63 : VEC_IN;
            @(negedge clock);
            exp_busy = (k >= 1 && k <= 4);
            exp_done = (k == 5);
            exp_out  = (k >= 5) ? VEC_OUT : 128'h0;
            n_checks++; if (busy4 !== exp_busy) $display("FAIL ignore_busy cycle %0d: got %b expected %b", k, busy4, exp_busy); else n_pass++;
            n_checks++; if (done4 !== exp_done) $display("FAIL ignore_done cycle %0d: got %b expected %b", k, done4, exp_done); else n_pass++;
            n_checks++; if (out4 !== exp_out) $display("FAIL ignore_out cycle %0d: got %h expected %h", k, out4, exp_out); else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        int done_count;
        int cyc;
        do_reset();
        begin_start(ALL_00);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clock);
            #1 start_transition = 1'b0;
        end
        @(negedge clock);
        n_checks++; if (out4 !== ALL_52) $display("FAIL abort_preload: got %h expected %h", out4, ALL_52); else n_pass++;

        begin_start(VEC_IN);
        @(posedge clock);
        #1 start_transition = 1'b0;
        @(posedge clock);
        @(negedge clock);
        n_checks++; if (busy4 !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", busy4); else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_checks++; if (out4 !== 128'h0) $display("FAIL abort_out: got %h expected %h", out4, 128'h0); else n_pass++;
        n_checks++; if (busy4 !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy4); else n_pass++;
        n_checks++; if (done4 !== 1'b0) $display("FAIL abort_done: got %b expected 0", done4); else n_pass++;
        @(posedge clock);
        #1 reset = 1'b0;
        done_count = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (done4) done_count++;
        end
        n_checks++; if (done_count !== 0) $display("FAIL abort_no_done: got %0d pulses expected 0", done_count); else n_pass++;

        begin_start(ALL_7C);
        cyc = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            #1 start_transition = 1'b0;
            @(negedge clock);
            if (done4 && cyc < 0) cyc = k;
        end
        n_checks++; if (cyc !== 5) $display("FAIL abort_restart_latency: got %0d expected 5", cyc); else n_pass++;
        n_checks++; if (out4 !== ALL_01) $display("FAIL abort_restart_out: got %h expected %h", out4, ALL_01); else n_pass++;
    endtask

    task automatic test_held_start();
        logic exp_done;
        do_reset();
        begin_start(VEC_IN);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1 start_transition = (k <= 19);
            @(negedge clock);
            exp_done = (k == 5 || k == 11 || k == 17);
            n_checks++; if (done4 !== exp_done) $display("FAIL held_done cycle %0d: got %b expected %b", k, done4, exp_done); else n_pass++;
            if (exp_done) begin
                n_checks++; if (out4 !== VEC_OUT) $display("FAIL held_out cycle %0d: got %h expected %h", k, out4, VEC_OUT); else n_pass++;
            end
        end
        start_transition = 1'b0;
    endtask

    task automatic test_bytes_per_cycle();
        int c4, c1, c16;
        logic busy16_c1;
        do_reset();
        begin_start(VEC_IN);
        c4 = -1; c1 = -1; c16 = -1;
        busy16_c1 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1 start_transition = 1'b0;
            @(negedge clock);
            if (k == 1) busy16_c1 = busy16;
            if (done4 && c4 < 0) c4 = k;
            if (done1 && c1 < 0) c1 = k;
            if (done16 && c16 < 0) c16 = k;
        end
        n_checks++; if (c4 !== 5) $display("FAIL bpc4_latency: got %0d expected 5", c4); else n_pass++;
        n_checks++; if (c1 !== 17) $display("FAIL bpc1_latency: got %0d expected 17", c1); else n_pass++;
        n_checks++; if (c16 !== 2) $display("FAIL bpc16_latency: got %0d expected 2", c16); else n_pass++;
        n_checks++; if (busy16_c1 !== 1'b1) $display("FAIL bpc16_busy: got %b expected 1", busy16_c1); else n_pass++;
        n_checks++; if (out4 !== VEC_OUT) $display("FAIL bpc4_out: got %h expected %h", out4, VEC_OUT); else n_pass++;
        n_checks++; if (out1 !== VEC_OUT) $display("FAIL bpc1_out: got %h expected %h", out1, VEC_OUT); else n_pass++;
        n_checks++; if (out16 !== VEC_OUT) $display("FAIL bpc16_out: got %h expected %h", out16, VEC_OUT); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_ignore_start();
        test_reset_abort();
        test_held_start();
        test_bytes_per_cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
